// File: rtl/sr_pkg.sv
// Shared types and helpers for the serial word receive path.
// Holding-buffer state encoding and counter width helper.
package sr_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rx_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Parameterized serial-to-parallel shift register.
// Idles at all ones; clear reloads that idle value synchronously.
module flex_stp_sr #(
    parameter int NUM_BITS  = 32,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    input  logic                clear,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] shifted;

    generate
        if (SHIFT_MSB) begin : g_msb
            assign shifted = {parallel_out[NUM_BITS-2:0], serial_in};
        end else begin : g_lsb
            assign shifted = {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
        end else if (clear) begin
            parallel_out <= '1;
        end else if (shift_enable) begin
            parallel_out <= shifted;
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a one-entry holding buffer,
// valid/ready handshake and sticky overrun flag.
module serial_word_rx
    import sr_pkg::*;
#(
    parameter int NUM_BITS  = 32,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        shift_enable,
    input  logic                        serial_in,
    input  logic                        sync_clear,
    output logic [NUM_BITS-1:0]         word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        overrun,
    output logic [$clog2(NUM_BITS)-1:0] bit_count
);

    localparam int CW = cnt_width(NUM_BITS);

    rx_state_t           state_q;
    rx_state_t           state_d;
    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] next_word;
    logic                last_bit;
    logic                complete;
    logic                load;
    logic                set_ovr;

    flex_stp_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .clear        (sync_clear),
        .parallel_out (sr_q)
    );

    // The completing bit never lands in sr_q before the word is captured.
    generate
        if (SHIFT_MSB) begin : g_msb
            assign next_word = {sr_q[NUM_BITS-2:0], serial_in};
        end else begin : g_lsb
            assign next_word = {serial_in, sr_q[NUM_BITS-1:1]};
        end
    endgenerate

    assign last_bit   = (bit_count == CW'(NUM_BITS - 1));
    assign complete   = shift_enable && last_bit;
    assign word_valid = (state_q == FULL);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count <= '0;
        end else if (sync_clear) begin
            bit_count <= '0;
        end else if (shift_enable) begin
            bit_count <= last_bit ? '0 : bit_count + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        set_ovr = 1'b0;
        if (sync_clear) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (complete) begin
                        load    = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (complete && word_ready) begin
                        load = 1'b1;
                    end else if (complete) begin
                        set_ovr = 1'b1;
                    end else if (word_ready) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= EMPTY;
            word_out <= '0;
            overrun  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                word_out <= next_word;
            end
            if (sync_clear) begin
                overrun <= 1'b0;
            end else if (set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx, MSB-first and LSB-first
// instances driven from the same serial stimulus.
module tb_serial_word_rx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       shift_enable = 1'b0;
    logic       serial_in = 1'b0;
    logic       sync_clear = 1'b0;
    logic       word_ready = 1'b0;

    logic [7:0] wo_m, wo_l;
    logic       wv_m, wv_l;
    logic       ov_m, ov_l;
    logic [2:0] bc_m, bc_l;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic [7:0] exp_m, exp_l;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_word_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_m (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .sync_clear   (sync_clear),
        .word_out     (wo_m),
        .word_valid   (wv_m),
        .word_ready   (word_ready),
        .overrun      (ov_m),
        .bit_count    (bc_m)
    );

    serial_word_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_l (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .sync_clear   (sync_clear),
        .word_out     (wo_l),
        .word_valid   (wv_l),
        .word_ready   (word_ready),
        .overrun      (ov_l),
        .bit_count    (bc_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[7] is the first bit on the wire
    task automatic send_bits(input logic [7:0] seq, input int gap, input bit push);
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            serial_in    = seq[7-i];
            tick();
            shift_enable = 1'b0;
            serial_in    = 1'b0;
            n_checks++;
            if (bc_m !== 3'((i + 1) % 8))
                $display("FAIL bit_count_shift: got %0d want %0d", bc_m, (i + 1) % 8);
            else n_pass++;
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    n_checks++;
                    if (bc_l !== 3'(i + 1))
                        $display("FAIL bit_count_gap: got %0d want %0d", bc_l, i + 1);
                    else n_pass++;
                end
            end
        end
        if (push) begin
            q_m.push_back(seq);
            q_l.push_back(rev8(seq));
        end
    endtask

    task automatic pop_compare(input string tag);
        if (q_m.size() == 0 || q_l.size() == 0) begin
            n_checks++;
            $display("FAIL %s_scoreboard: queue empty", tag);
            return;
        end
        exp_m = q_m.pop_front();
        exp_l = q_l.pop_front();
        n_checks++;
        if (wv_m !== 1'b1 || wo_m !== exp_m)
            $display("FAIL %s_msb: got v=%b w=%h want v=1 w=%h", tag, wv_m, wo_m, exp_m);
        else n_pass++;
        n_checks++;
        if (wv_l !== 1'b1 || wo_l !== exp_l)
            $display("FAIL %s_lsb: got v=%b w=%h want v=1 w=%h", tag, wv_l, wo_l, exp_l);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        n_checks++;
        if ({wo_m, wv_m, ov_m, bc_m} !== 13'd0)
            $display("FAIL reset_msb: got w=%h v=%b o=%b c=%0d want 0", wo_m, wv_m, ov_m, bc_m);
        else n_pass++;
        n_checks++;
        if ({wo_l, wv_l, ov_l, bc_l} !== 13'd0)
            $display("FAIL reset_lsb: got w=%h v=%b o=%b c=%0d want 0", wo_l, wv_l, ov_l, bc_l);
        else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_bits(8'b0001_1110, 0, 1'b1);
        n_checks++;
        if (wo_m !== 8'h1E) $display("FAIL basic_const: got %h want 1e", wo_m);
        else n_pass++;
        n_checks++;
        if (wo_l !== 8'h78) $display("FAIL basic_const_lsb: got %h want 78", wo_l);
        else n_pass++;
        pop_compare("basic");
        tick();
        n_checks++;
        if (wv_m !== 1'b0 || wv_l !== 1'b0)
            $display("FAIL basic_one_cycle: got %b/%b want 0/0", wv_m, wv_l);
        else n_pass++;
    endtask

    task automatic test_gaps();
        word_ready = 1'b1;
        send_bits(8'b0001_1110, 3, 1'b1);
        pop_compare("gaps");
        tick();
    endtask

    task automatic test_overrun();
        word_ready = 1'b0;
        send_bits(8'h1E, 0, 1'b1);
        pop_compare("ovr_first");
        send_bits(8'hA5, 0, 1'b0);
        n_checks++;
        if (wv_m !== 1'b1 || wo_m !== 8'h1E || ov_m !== 1'b1)
            $display("FAIL ovr_drop: got v=%b w=%h o=%b want v=1 w=1e o=1", wv_m, wo_m, ov_m);
        else n_pass++;
        word_ready = 1'b1;
        tick();
        n_checks++;
        if (wv_m !== 1'b0 || ov_m !== 1'b1 || wo_m !== 8'h1E)
            $display("FAIL ovr_drain: got v=%b o=%b w=%h want v=0 o=1 w=1e", wv_m, ov_m, wo_m);
        else n_pass++;
        tick();
        n_checks++;
        if (ov_m !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", ov_m);
        else n_pass++;
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        n_checks++;
        if (ov_m !== 1'b0 || ov_l !== 1'b0)
            $display("FAIL ovr_clear: got %b/%b want 0/0", ov_m, ov_l);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq;
        seq = 8'hA5;
        word_ready = 1'b0;
        send_bits(8'h1E, 0, 1'b1);
        pop_compare("b2b_first");
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            serial_in    = seq[7-i];
            if (i == 7) word_ready = 1'b1;
            tick();
        end
        shift_enable = 1'b0;
        q_m.push_back(seq);
        q_l.push_back(rev8(seq));
        pop_compare("b2b_reload");
        n_checks++;
        if (ov_m !== 1'b0) $display("FAIL b2b_no_ovr: got %b want 0", ov_m);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            seq = 8'($urandom_range(0, 255));
            send_bits(seq, 0, 1'b1);
            pop_compare("b2b_stream");
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] seq;
        seq = 8'b1011_0110;
        word_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            shift_enable = 1'b1;
            serial_in    = seq[7-i];
            tick();
        end
        shift_enable = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({wo_m, wv_m, ov_m, bc_m} !== 13'd0)
            $display("FAIL async_rst: got w=%h v=%b o=%b c=%0d want 0", wo_m, wv_m, ov_m, bc_m);
        else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        send_bits(8'h3C, 0, 1'b1);
        pop_compare("async_rst_word");
        tick();
    endtask

    task automatic test_sync_clear();
        logic [7:0] seq;
        seq = 8'h5A;
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            serial_in    = seq[7-i];
            if (i == 7) sync_clear = 1'b1;
            tick();
        end
        shift_enable = 1'b0;
        sync_clear   = 1'b0;
        n_checks++;
        if (wv_m !== 1'b0 || bc_m !== 3'd0 || wo_m !== 8'h3C)
            $display("FAIL sclr_cut: got v=%b c=%0d w=%h want v=0 c=0 w=3c", wv_m, bc_m, wo_m);
        else n_pass++;
        send_bits(8'hF0, 0, 1'b1);
        n_checks++;
        if (wo_m !== 8'hF0) $display("FAIL sclr_next_const: got %h want f0", wo_m);
        else n_pass++;
        pop_compare("sclr_next");
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_sync_clear();
        n_checks++;
        if (q_m.size() != 0)
            $display("FAIL scoreboard_drain: got %0d left want 0", q_m.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
